spartan_arb2: RTL and testbench

- Two-to-one arbiter that shares one downstream Spartan slave port (e.g. a FIFO bridge slave) between two Spartan masters.
- Grants whole request packets (read request, or write header through last write beat) to one master at a time.
- Records grant order in a small ordering FIFO and routes each in-order response packet back to its originating master.
- Zero-latency combinational pass-through of bus beats; only arbitration and ordering state is registered.

---
 rtl/spartan_arb2.sv | 150 +++++++++++++++
 tb/tb_spartan_arb2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spartan_arb2.sv
// Two-master to one-slave Spartan arbiter with packet locking and in-order response routing.
// Build option SPARTAN_ARB2_FIXED_PRIO_EN: master 0 always wins ties (no round-robin state).
module spartan_arb2 #(
    parameter int BWIDTH    = 64,
    parameter int ORD_DEPTH = 4,
    parameter int ORD_AW    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [BWIDTH+1:0] SpMBUS0,
    input  logic              SpMVLD0,
    output logic              SpMRDY0,
    output logic [BWIDTH+1:0] SpSBUS0,
    output logic              SpSVLD0,
    input  logic              SpSRDY0,
    input  logic [BWIDTH+1:0] SpMBUS1,
    input  logic              SpMVLD1,
    output logic              SpMRDY1,
    output logic [BWIDTH+1:0] SpSBUS1,
    output logic              SpSVLD1,
    input  logic              SpSRDY1,
    output logic [BWIDTH+1:0] SpMBUS,
    output logic              SpMVLD,
    input  logic              SpMRDY,
    input  logic [BWIDTH+1:0] SpSBUS,
    input  logic              SpSVLD,
    output logic              SpSRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state;
    logic              ord_mem [ORD_DEPTH];
    logic [ORD_AW-1:0] wr_ptr;
    logic [ORD_AW-1:0] rd_ptr;
    logic [ORD_AW:0]   ord_cnt;
`ifndef SPARTAN_ARB2_FIXED_PRIO_EN
    logic              rr_last;
`endif

    logic       full, empty, win, sel0, sel1;
    logic       m_xfer, m_end, push, pop, head;
    logic [1:0] mhdr, shdr;

    always_comb begin
        full  = (ord_cnt == (ORD_AW+1)'(ORD_DEPTH));
        empty = (ord_cnt == '0);
`ifdef SPARTAN_ARB2_FIXED_PRIO_EN
        win = !SpMVLD0;
`else
        win = (SpMVLD0 && SpMVLD1) ? !rr_last : SpMVLD1;
`endif
        sel0 = 1'b0;
        sel1 = 1'b0;
        case (state)
            IDLE: begin
                if (!full && (SpMVLD0 || SpMVLD1)) begin
                    sel0 = !win;
                    sel1 = win;
                end
            end
            OWN0:    sel0 = 1'b1;
            OWN1:    sel1 = 1'b1;
            default: ;
        endcase

        // Grant select depends only on state and request valids, never on SpMRDY.
        SpMBUS  = sel1 ? SpMBUS1 : SpMBUS0;
        SpMVLD  = (sel0 && SpMVLD0) || (sel1 && SpMVLD1);
        SpMRDY0 = sel0 && SpMRDY;
        SpMRDY1 = sel1 && SpMRDY;
        mhdr    = SpMBUS[BWIDTH+1:BWIDTH];
        m_xfer  = SpMVLD && SpMRDY;
        m_end   = (mhdr == 2'b00) || (mhdr == 2'b11);
        push    = m_xfer && (state == IDLE);

        head    = ord_mem[rd_ptr];
        SpSBUS0 = SpSBUS;
        SpSBUS1 = SpSBUS;
        SpSVLD0 = !empty && !head && SpSVLD;
        SpSVLD1 = !empty && head && SpSVLD;
        SpSRDY  = empty ? 1'b1 : (head ? SpSRDY1 : SpSRDY0);
        shdr    = SpSBUS[BWIDTH+1:BWIDTH];
        pop     = !empty && SpSVLD && SpSRDY && ((shdr == 2'b11) || (shdr == 2'b00));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ord_cnt <= '0;
`ifndef SPARTAN_ARB2_FIXED_PRIO_EN
            rr_last <= 1'b1;
`endif
            for (int unsigned i = 0; i < ORD_DEPTH; i++) begin
                ord_mem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                ord_mem[wr_ptr] <= sel1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   ord_cnt <= ord_cnt + 1'b1;
                2'b01:   ord_cnt <= ord_cnt - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (m_xfer) begin
                        if (m_end) begin
`ifndef SPARTAN_ARB2_FIXED_PRIO_EN
                            rr_last <= sel1;
`endif
                        end else begin
                            state <= sel1 ? OWN1 : OWN0;
                        end
                    end
                end
                OWN0: begin
                    if (m_xfer && m_end) begin
                        state <= IDLE;
`ifndef SPARTAN_ARB2_FIXED_PRIO_EN
                        rr_last <= 1'b0;
`endif
                    end
                end
                OWN1: begin
                    if (m_xfer && m_end) begin
                        state <= IDLE;
`ifndef SPARTAN_ARB2_FIXED_PRIO_EN
                        rr_last <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spartan_arb2.sv
// Directed self-checking bench for spartan_arb2 (default round-robin or fixed-priority build).
module tb_spartan_arb2;

    localparam int BW = 64;

    logic          CLK = 1'b0;
    logic          RST;
    logic [BW+1:0] SpMBUS0, SpMBUS1, SpMBUS, SpSBUS, SpSBUS0, SpSBUS1;
    logic          SpMVLD0, SpMRDY0, SpSVLD0, SpSRDY0;
    logic          SpMVLD1, SpMRDY1, SpSVLD1, SpSRDY1;
    logic          SpMVLD, SpMRDY, SpSVLD, SpSRDY;

    int n_chk  = 0;
    int n_pass = 0;

    spartan_arb2 #(.BWIDTH(BW), .ORD_DEPTH(4), .ORD_AW(2)) dut (
        .CLK(CLK), .RST(RST),
        .SpMBUS0(SpMBUS0), .SpMVLD0(SpMVLD0), .SpMRDY0(SpMRDY0),
        .SpSBUS0(SpSBUS0), .SpSVLD0(SpSVLD0), .SpSRDY0(SpSRDY0),
        .SpMBUS1(SpMBUS1), .SpMVLD1(SpMVLD1), .SpMRDY1(SpMRDY1),
        .SpSBUS1(SpSBUS1), .SpSVLD1(SpSVLD1), .SpSRDY1(SpSRDY1),
        .SpMBUS(SpMBUS), .SpMVLD(SpMVLD), .SpMRDY(SpMRDY),
        .SpSBUS(SpSBUS), .SpSVLD(SpSVLD), .SpSRDY(SpSRDY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [BW+1:0] got, input logic [BW+1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [BW+1:0] mk(input logic [1:0] h, input logic [BW-1:0] d);
        return {h, d};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        SpMVLD0 = 1'b0; SpMVLD1 = 1'b0; SpSVLD = 1'b0;
        SpMRDY = 1'b1; SpSRDY0 = 1'b1; SpSRDY1 = 1'b1;
        tick();
        RST = 1'b0;
        #1;
    endtask

    logic [1:0]    wh [4];
    logic [1:0]    rh [3];
    logic [BW+1:0] rdq, m1rd, rsp;
    int            g;

    initial begin
        wh = '{2'b01, 2'b10, 2'b10, 2'b11};
        rh = '{2'b01, 2'b10, 2'b11};
        SpMBUS0 = '0; SpMBUS1 = '0; SpSBUS = '0;
        RST = 1'b1;
        SpMVLD0 = 1'b0; SpMVLD1 = 1'b0; SpSVLD = 1'b0;
        SpMRDY = 1'b1; SpSRDY0 = 1'b1; SpSRDY1 = 1'b1;
        repeat (2) tick();
        check("rst_mrdy0", SpMRDY0, 0);
        check("rst_mrdy1", SpMRDY1, 0);
        check("rst_mvld", SpMVLD, 0);
        check("rst_srdy", SpSRDY, 1);
        check("rst_svld0", SpSVLD0, 0);
        check("rst_svld1", SpSVLD1, 0);
        check("rst_cnt", dut.ord_cnt, 0);
        check("rst_state", dut.state, 0);
        RST = 1'b0;
        #1;

        // Single read from M0, ID 5'h3 in [45:41]
        rdq = mk(2'b00, 64'h0000_0600_0000_0000);
        SpMBUS0 = rdq; SpMVLD0 = 1'b1; SpMRDY = 1'b0;
        #1;
        check("rd_bus", SpMBUS, rdq);
        check("rd_mvld", SpMVLD, 1);
        check("rd_mrdy0_hold", SpMRDY0, 0);
        SpMRDY = 1'b1;
        #1;
        check("rd_mrdy0", SpMRDY0, 1);
        check("rd_mrdy1", SpMRDY1, 0);
        tick();
        SpMVLD0 = 1'b0;
        check("rd_cnt1", dut.ord_cnt, 1);
        check("rd_state", dut.state, 0);
        SpSBUS = mk(2'b01, 64'hA0); SpSVLD = 1'b1; SpSRDY0 = 1'b0;
        #1;
        check("rsp_stall_srdy", SpSRDY, 0);
        tick();
        SpSRDY0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rsp = mk(rh[i], 64'hA0 + 64'(i));
            SpSBUS = rsp;
            #1;
            check("rsp_svld0", SpSVLD0, 1);
            check("rsp_svld1", SpSVLD1, 0);
            check("rsp_bus0", SpSBUS0, rsp);
            check("rsp_srdy", SpSRDY, 1);
            tick();
            check("rsp_cnt", dut.ord_cnt, (i < 2) ? 1 : 0);
        end
        SpSVLD = 1'b0;

        // M0 write locks out M1 read
        m1rd = mk(2'b00, 64'h1111);
        for (int i = 0; i < 4; i++) begin
            SpMBUS0 = mk(wh[i], 64'hC0 + 64'(i)); SpMVLD0 = 1'b1;
            if (i > 0) begin SpMBUS1 = m1rd; SpMVLD1 = 1'b1; end
            #1;
            check("wr_mrdy0", SpMRDY0, 1);
            check("wr_mrdy1", SpMRDY1, 0);
            check("wr_bus", SpMBUS, mk(wh[i], 64'hC0 + 64'(i)));
            tick();
            check("wr_state", dut.state, (i < 3) ? 1 : 0);
        end
        SpMVLD0 = 1'b0;
        #1;
        check("m1_grant", SpMRDY1, 1);
        check("m1_bus", SpMBUS, m1rd);
        tick();
        SpMVLD1 = 1'b0;
        check("m1_cnt", dut.ord_cnt, 2);
        SpSBUS = mk(2'b00, 64'hD0); SpSVLD = 1'b1;
        #1;
        check("wrsp_svld0", SpSVLD0, 1);
        check("wrsp_svld1", SpSVLD1, 0);
        tick();
        check("wrsp_cnt", dut.ord_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            SpSBUS = mk(rh[i], 64'hE0);
            #1;
            check("m1rsp_svld1", SpSVLD1, 1);
            check("m1rsp_svld0", SpSVLD0, 0);
            tick();
        end
        SpSVLD = 1'b0;
        check("m1rsp_cnt", dut.ord_cnt, 0);

        // Continuous reads from both masters until the ordering FIFO fills
        do_reset();
        SpMBUS0 = mk(2'b00, 64'hB0); SpMBUS1 = mk(2'b00, 64'hB1);
        SpMVLD0 = 1'b1; SpMVLD1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef SPARTAN_ARB2_FIXED_PRIO_EN
            g = 0;
`else
            g = i % 2;
`endif
            #1;
            check("alt_mrdy0", SpMRDY0, (g == 0) ? 1 : 0);
            check("alt_mrdy1", SpMRDY1, (g == 1) ? 1 : 0);
            check("alt_bus", SpMBUS, (g == 1) ? mk(2'b00, 64'hB1) : mk(2'b00, 64'hB0));
            tick();
        end
        check("full_cnt", dut.ord_cnt, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef SPARTAN_ARB2_FIXED_PRIO_EN
            check("ord_entry", dut.ord_mem[i], 0);
`else
            check("ord_entry", dut.ord_mem[i], i % 2);
`endif
        end
        #1;
        check("full_mrdy0", SpMRDY0, 0);
        check("full_mrdy1", SpMRDY1, 0);
        check("full_mvld", SpMVLD, 0);
        tick();
        check("full_hold_cnt", dut.ord_cnt, 4);
        SpSBUS = mk(2'b00, 64'hF0); SpSVLD = 1'b1;
        #1;
        check("full_rsp_svld0", SpSVLD0, 1);
        check("full_rsp_svld1", SpSVLD1, 0);
        check("full_rsp_mrdy0", SpMRDY0, 0);
        tick();
        SpSVLD = 1'b0;
        check("pop_cnt", dut.ord_cnt, 3);
        #1;
        check("fifth_mrdy0", SpMRDY0, 1);
        check("fifth_mrdy1", SpMRDY1, 0);
        tick();
        check("fifth_cnt", dut.ord_cnt, 4);
        SpMVLD0 = 1'b0; SpMVLD1 = 1'b0;

        // Spurious response with empty FIFO is dropped
        do_reset();
        SpSBUS = mk(2'b00, 64'h99); SpSVLD = 1'b1; SpSRDY0 = 1'b0; SpSRDY1 = 1'b0;
        #1;
        check("drop_srdy", SpSRDY, 1);
        check("drop_svld0", SpSVLD0, 0);
        check("drop_svld1", SpSVLD1, 0);
        tick();
        check("drop_cnt", dut.ord_cnt, 0);
        check("drop_state", dut.state, 0);
        SpSVLD = 1'b0; SpSRDY0 = 1'b1; SpSRDY1 = 1'b1;

        // Reset while M1 owns the bus mid-write with two entries queued
        SpMBUS1 = mk(2'b00, 64'h21); SpMVLD1 = 1'b1;
        tick();
        SpMBUS1 = mk(2'b01, 64'h22);
        tick();
        check("own1_state", dut.state, 2);
        check("own1_cnt", dut.ord_cnt, 2);
        SpMBUS1 = mk(2'b10, 64'h23);
        tick();
        check("own1_hold", dut.state, 2);
        RST = 1'b1;
        #1;
        check("mid_rst_state", dut.state, 0);
        check("mid_rst_cnt", dut.ord_cnt, 0);
        tick();
        RST = 1'b0; SpMVLD1 = 1'b0;
        SpMBUS0 = mk(2'b00, 64'h30); SpMVLD0 = 1'b1;
        #1;
        check("post_rst_mrdy0", SpMRDY0, 1);
        tick();
        SpMVLD0 = 1'b0;
        check("post_rst_cnt", dut.ord_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
